// File: rtl/display_pkg.sv
// display_pkg: shared timing types, 720p defaults and blanking-limit helper
package display_pkg;
  typedef struct packed {
    int h_res;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_res;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;
  typedef struct packed {
    int sta;
    int s_sta;
    int s_end;
    int a_end;
  } limits_t;
  localparam timing_t T720P = '{1280, 110, 40, 220, 720, 5, 5, 20};
  function automatic limits_t calc_limits(timing_t t, logic vert);
    limits_t l;
    int res = vert ? t.v_res : t.h_res;
    int fp = vert ? t.v_fp : t.h_fp;
    int sync = vert ? t.v_sync : t.h_sync;
    int bp = vert ? t.v_bp : t.h_bp;
    l.sta = -(fp + sync + bp);
    l.s_sta = l.sta + fp;
    l.s_end = l.s_sta + sync;
    l.a_end = res - 1;
    return l;
  endfunction
  function automatic logic fits16(limits_t l);
    return l.sta >= -32768 && l.a_end <= 32767 && l.sta <= l.s_sta && l.s_end <= 32767;
  endfunction
endpackage

// File: rtl/sig_delay.sv
// sig_delay: synchronous-reset shift register with per-bit reset value
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  localparam int DW = DEPTH * WIDTH;
  logic [DW-1:0] pipe_q, pipe_d;
  always_comb pipe_d = DW'({pipe_q, i_d});
  always_ff @(posedge clk) pipe_q <= rst ? {DEPTH{RST_VAL}} : pipe_d;
  assign o_q = pipe_q[DW-1 -: WIDTH];
endmodule

// File: rtl/display_timing_gen.sv
// display_timing_gen: signed-coordinate raster timing with painter-latency-matched tx stage
module display_timing_gen import display_pkg::*; #(
  parameter int H_RES     = T720P.h_res,
  parameter int V_RES     = T720P.v_res,
  parameter int H_FP      = T720P.h_fp,
  parameter int H_SYNC    = T720P.h_sync,
  parameter int H_BP      = T720P.h_bp,
  parameter int V_FP      = T720P.v_fp,
  parameter int V_SYNC    = T720P.v_sync,
  parameter int V_BP      = T720P.v_bp,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int PAINT_LAT = 0
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  output logic signed [15:0] o_sx,
  output logic signed [15:0] o_sy,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_frame,
  output logic               o_line,
  input  logic [7:0]         i_red,
  input  logic [7:0]         i_green,
  input  logic [7:0]         i_blue,
  output logic [7:0]         o_tx_red,
  output logic [7:0]         o_tx_green,
  output logic [7:0]         o_tx_blue,
  output logic               o_tx_hsync,
  output logic               o_tx_vsync,
  output logic               o_tx_de
);
  localparam timing_t TIM = '{H_RES, H_FP, H_SYNC, H_BP, V_RES, V_FP, V_SYNC, V_BP};
  localparam limits_t HL = calc_limits(TIM, 1'b0);
  localparam limits_t VL = calc_limits(TIM, 1'b1);
  localparam logic signed [15:0] H_STA  = 16'(HL.sta);
  localparam logic signed [15:0] HS_STA = 16'(HL.s_sta);
  localparam logic signed [15:0] HS_END = 16'(HL.s_end);
  localparam logic signed [15:0] HA_END = 16'(HL.a_end);
  localparam logic signed [15:0] V_STA  = 16'(VL.sta);
  localparam logic signed [15:0] VS_STA = 16'(VL.s_sta);
  localparam logic signed [15:0] VS_END = 16'(VL.s_end);
  localparam logic signed [15:0] VA_END = 16'(VL.a_end);
  localparam logic [2:0] SYNC_RST = {!H_POL, !V_POL, 1'b0};
  if (!fits16(HL) || !fits16(VL)) begin : g_range_err
    $error("display_timing_gen: timing limit outside 16-bit signed range");
  end
  if (PAINT_LAT < 0 || PAINT_LAT > 7) begin : g_lat_err
    $error("display_timing_gen: PAINT_LAT must be 0..7");
  end
  logic signed [15:0] sx_q, sx_d, sy_q, sy_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, line_q, line_d, frame_q, frame_d;
  logic [23:0] rgb_q, rgb_d;
  logic [2:0] tx_sync;
  // Strobes and syncs are decoded from the next coordinate so they register alongside it
  always_comb begin
    sx_d = (sx_q == HA_END) ? H_STA : sx_q + 16'sd1;
    sy_d = (sx_q != HA_END) ? sy_q : (sy_q == VA_END) ? V_STA : sy_q + 16'sd1;
    hs_d = (sx_d >= HS_STA && sx_d < HS_END) ? H_POL : !H_POL;
    vs_d = (sy_d >= VS_STA && sy_d < VS_END) ? V_POL : !V_POL;
    de_d = !sx_d[15] && !sy_d[15];
    line_d = sx_d == H_STA;
    frame_d = line_d && sy_d == V_STA;
    rgb_d = {i_red, i_green, i_blue};
  end
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx_q <= H_STA;
      sy_q <= V_STA;
      hs_q <= !H_POL;
      vs_q <= !V_POL;
      de_q <= 1'b0;
      line_q <= 1'b0;
      frame_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      line_q <= line_d;
      frame_q <= frame_d;
      rgb_q <= rgb_d;
    end
  end
  sig_delay #(.WIDTH(3), .DEPTH(PAINT_LAT + 1), .RST_VAL(SYNC_RST)) u_sync_dly (
    .clk(clk_pix),
    .rst(rst_pix),
    .i_d({hs_q, vs_q, de_q}),
    .o_q(tx_sync)
  );
  always_comb begin
    o_tx_red = tx_sync[0] ? rgb_q[23:16] : 8'd0;
    o_tx_green = tx_sync[0] ? rgb_q[15:8] : 8'd0;
    o_tx_blue = tx_sync[0] ? rgb_q[7:0] : 8'd0;
  end
  assign o_sx = sx_q;
  assign o_sy = sy_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_de = de_q;
  assign o_line = line_q;
  assign o_frame = frame_q;
  assign o_tx_hsync = tx_sync[2];
  assign o_tx_vsync = tx_sync[1];
  assign o_tx_de = tx_sync[0];
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: directed checks on 720p, a tiny raster with PAINT_LAT=2, and 640x480
module tb_display_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic signed [15:0] sx_a, sy_a;
  logic hs_a, vs_a, de_a, fr_a, ln_a, ths_a, tvs_a, tde_a;
  logic [7:0] tr_a, tg_a, tb_a;
  display_timing_gen u_a (
    .clk_pix(clk), .rst_pix(rst_a), .o_sx(sx_a), .o_sy(sy_a), .o_hsync(hs_a), .o_vsync(vs_a),
    .o_de(de_a), .o_frame(fr_a), .o_line(ln_a), .i_red(sx_a[7:0]), .i_green(sy_a[7:0]), .i_blue(8'h5A),
    .o_tx_red(tr_a), .o_tx_green(tg_a), .o_tx_blue(tb_a), .o_tx_hsync(ths_a), .o_tx_vsync(tvs_a), .o_tx_de(tde_a)
  );

  logic signed [15:0] sx_b, sy_b;
  logic hs_b, vs_b, de_b, fr_b, ln_b, ths_b, tvs_b, tde_b;
  logic [7:0] tr_b, tg_b, tb_b;
  logic [23:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= {sx_b[7:0], sy_b[7:0], 8'h5A};
    p2 <= p1;
  end
  display_timing_gen #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PAINT_LAT(2)
  ) u_b (
    .clk_pix(clk), .rst_pix(rst_b), .o_sx(sx_b), .o_sy(sy_b), .o_hsync(hs_b), .o_vsync(vs_b),
    .o_de(de_b), .o_frame(fr_b), .o_line(ln_b), .i_red(p2[23:16]), .i_green(p2[15:8]), .i_blue(p2[7:0]),
    .o_tx_red(tr_b), .o_tx_green(tg_b), .o_tx_blue(tb_b), .o_tx_hsync(ths_b), .o_tx_vsync(tvs_b), .o_tx_de(tde_b)
  );

  logic signed [15:0] sx_c, sy_c;
  logic hs_c, vs_c, de_c, fr_c, ln_c, ths_c, tvs_c, tde_c;
  logic [7:0] tr_c, tg_c, tb_c;
  display_timing_gen #(
    .H_RES(640), .H_FP(16), .H_SYNC(96), .H_BP(48), .V_RES(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_c (
    .clk_pix(clk), .rst_pix(rst_c), .o_sx(sx_c), .o_sy(sy_c), .o_hsync(hs_c), .o_vsync(vs_c),
    .o_de(de_c), .o_frame(fr_c), .o_line(ln_c), .i_red(sx_c[7:0]), .i_green(sy_c[7:0]), .i_blue(8'hA5),
    .o_tx_red(tr_c), .o_tx_green(tg_c), .o_tx_blue(tb_c), .o_tx_hsync(ths_c), .o_tx_vsync(tvs_c), .o_tx_de(tde_c)
  );

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // fl = {hs, vs, de, line, frame}; tf = {tx_hs, tx_vs, tx_de}; k = cycles since release
  typedef struct {
    int k;
    int sx;
    int sy;
    logic [4:0] fl;
    logic [2:0] tf;
    logic [23:0] rgb;
  } vec_t;
  vec_t v[19];

  int cur, n_hs, n_vs, n_de, n_ln, n_fr, n_tde, bad, ln_k, hs_first, hs_last, glitch;
  logic org_seen;

  initial begin
    v[0]  = '{0,   -9, -6, 5'b00000, 3'b000, 24'h0};
    v[1]  = '{2,   -7, -6, 5'b10000, 3'b000, 24'h0};
    v[2]  = '{4,   -5, -6, 5'b10000, 3'b000, 24'h0};
    v[3]  = '{5,   -4, -6, 5'b00000, 3'b100, 24'h0};
    v[4]  = '{9,    0, -6, 5'b00000, 3'b000, 24'h0};
    v[5]  = '{24,  15, -6, 5'b00000, 3'b000, 24'h0};
    v[6]  = '{25,  -9, -5, 5'b01010, 3'b000, 24'h0};
    v[7]  = '{26,  -8, -5, 5'b01000, 3'b000, 24'h0};
    v[8]  = '{50,  -9, -4, 5'b01010, 3'b010, 24'h0};
    v[9]  = '{75,  -9, -3, 5'b00010, 3'b010, 24'h0};
    v[10] = '{159,  0,  0, 5'b00100, 3'b000, 24'h0};
    v[11] = '{161,  2,  0, 5'b00100, 3'b000, 24'h0};
    v[12] = '{162,  3,  0, 5'b00100, 3'b001, 24'h00005A};
    v[13] = '{174, 15,  0, 5'b00100, 3'b001, 24'h0C005A};
    v[14] = '{175, -9,  1, 5'b00010, 3'b001, 24'h0D005A};
    v[15] = '{178, -6,  1, 5'b10000, 3'b000, 24'h0};
    v[16] = '{299, 15,  5, 5'b00100, 3'b001, 24'h0C055A};
    v[17] = '{300, -9, -6, 5'b00011, 3'b001, 24'h0D055A};
    v[18] = '{301, -8, -6, 5'b00000, 3'b001, 24'h0E055A};

    repeat (5) @(negedge clk);
    chk("720 reset coord", {sx_a, sy_a}, {16'(-370), 16'(-30)});
    chk("720 reset flags", {hs_a, vs_a, de_a, ln_a, fr_a}, 5'b00000);
    chk("720 reset tx", {ths_a, tvs_a, tde_a, tr_a, tg_a, tb_a}, 27'h0);
    chk("vga reset coord", {sx_c, sy_c}, {16'(-160), 16'(-45)});
    chk("vga reset flags", {hs_c, vs_c, de_c, ln_c, fr_c}, 5'b11000);
    chk("vga reset tx", {ths_c, tvs_c, tde_c, tr_c, tg_c, tb_c}, {3'b110, 24'h0});

    rst_b = 1'b0;
    cur = 0;
    for (int i = 0; i < 19; i++) begin
      repeat (v[i].k - cur) @(negedge clk);
      cur = v[i].k;
      chk($sformatf("vec%0d coord", i), {sx_b, sy_b}, {16'(v[i].sx), 16'(v[i].sy)});
      chk($sformatf("vec%0d flags", i), {hs_b, vs_b, de_b, ln_b, fr_b}, v[i].fl);
      chk($sformatf("vec%0d tx", i), {ths_b, tvs_b, tde_b, tr_b, tg_b, tb_b}, {v[i].tf, v[i].rgb});
    end

    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    n_hs = 0; n_vs = 0; n_de = 0; n_ln = 0; n_fr = 0; n_tde = 0; bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      n_hs += int'(hs_b);
      n_vs += int'(vs_b);
      n_de += int'(de_b);
      n_ln += int'(ln_b);
      n_fr += int'(fr_b);
      n_tde += int'(tde_b);
      if (!tde_b && {tr_b, tg_b, tb_b} != 24'h0) bad++;
    end
    chk("small hsync cycles/frame", n_hs, 36);
    chk("small vsync cycles/frame", n_vs, 50);
    chk("small de cycles/frame", n_de, 96);
    chk("small line strobes", n_ln, 12);
    chk("small frame strobes", n_fr, 1);
    chk("small tx_de cycles", n_tde, 94);
    chk("small blank colour zero", bad, 0);

    rst_c = 1'b0;
    n_hs = 0; n_ln = 0; ln_k = -1;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (!hs_c) n_hs++;
      if (ln_c) begin n_ln++; ln_k = k; end
    end
    chk("vga hsync low cycles", n_hs, 96);
    chk("vga line strobes", n_ln, 1);
    chk("vga line period", ln_k, 800);
    chk("vga coord after one line", {sx_c, sy_c}, {16'(-160), 16'(-44)});

    rst_a = 1'b0;
    chk("720 release no strobe", {ln_a, fr_a}, 2'b00);
    n_hs = 0; n_de = 0; n_ln = 0; n_fr = 0; bad = 0; ln_k = -1; hs_first = 0; hs_last = 0; org_seen = 1'b0;
    for (int k = 1; k <= 51150; k++) begin
      @(negedge clk);
      if (org_seen) chk("720 tx origin pixel", {tde_a, tr_a, tg_a, tb_a}, {1'b1, 24'h00005A});
      org_seen = (sx_a == 0 && sy_a == 0);
      if (k <= 1650 && hs_a) begin
        if (n_hs == 0) hs_first = sx_a;
        hs_last = sx_a;
        n_hs++;
      end
      if (ln_a) begin
        n_ln++;
        if (ln_k < 0) ln_k = k;
      end
      n_fr += int'(fr_a);
      if (k >= 49500 && k < 51150 && de_a) n_de++;
      if (!tde_a && {tr_a, tg_a, tb_a} != 24'h0) bad++;
    end
    chk("720 hsync cycles", n_hs, 40);
    chk("720 hsync first sx", hs_first, -260);
    chk("720 hsync last sx", hs_last, -221);
    chk("720 first line strobe", ln_k, 1650);
    chk("720 line strobes", n_ln, 31);
    chk("720 no early frame", n_fr, 0);
    chk("720 de on active line", n_de, 1280);
    chk("720 blank colour zero", bad, 0);

    for (int i = 0; i < 4000 && sx_a != 16'sd500; i++) @(negedge clk);
    chk("720 reached sx 500", sx_a, 500);
    rst_a = 1'b1;
    @(negedge clk);
    chk("720 midline reset coord", {sx_a, sy_a}, {16'(-370), 16'(-30)});
    chk("720 midline reset tx", {ths_a, tvs_a, tde_a, tr_a, tg_a, tb_a}, 27'h0);
    glitch = int'(ln_a | fr_a);
    repeat (2) begin
      @(negedge clk);
      glitch += int'(ln_a | fr_a);
    end
    rst_a = 1'b0;
    glitch += int'(ln_a | fr_a);
    @(negedge clk);
    glitch += int'(ln_a | fr_a);
    chk("720 no strobe glitch", glitch, 0);
    chk("720 resumes after reset", {sx_a, sy_a}, {16'(-369), 16'(-30)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
